// File: rtl/add_pipe.sv
// add_pipe: pipelined add/subtract of two WIDTH-bit unsigned operands through
// LAT register stages, with valid/ready handshakes on both sides.
// The arithmetic is done in stage 0. Later stages only move the result forward.
// Optional feature macro: ADD_PIPE_SAT_EN. When it is defined, results saturate
// and sat flags the clamp. When it is undefined, results wrap and sat stays 0.
module add_pipe #(
    parameter int WIDTH = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y,
    output logic             sat
);

    // Each stage holds {sat, y}. Bit WIDTH+1 is the saturation flag.
    logic [WIDTH+1:0] stage_r [LAT];
    logic [LAT-1:0]   valid_r;
    logic [LAT-1:0]   ready_s;

    // Produce the packed {sat, y} word for one operand set.
    function automatic logic [WIDTH+1:0] compute(
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v,
        input logic             sub_v
    );
        logic [WIDTH:0]   raw_v;
        logic [WIDTH+1:0] res_v;
        if (sub_v) begin
            raw_v = {1'b0, a_v} - {1'b0, b_v};
        end else begin
            raw_v = {1'b0, a_v} + {1'b0, b_v};
        end
`ifdef ADD_PIPE_SAT_EN
        // The top bit is the carry for an add and the borrow for a subtract.
        if (raw_v[WIDTH]) begin
            if (sub_v) begin
                res_v = {1'b1, {(WIDTH+1){1'b0}}};
            end else begin
                res_v = {1'b1, 1'b0, {WIDTH{1'b1}}};
            end
        end else begin
            res_v = {1'b0, raw_v};
        end
`else
        res_v = {1'b0, raw_v};
`endif
        return res_v;
    endfunction

    // Stall chain: a stage can load when it is empty or its content moves on.
    // An empty stage downstream therefore never blocks the stages above it.
    always_comb begin
        ready_s = '0;
        ready_s[LAT-1] = !valid_r[LAT-1] | out_ready;
        for (int k = LAT - 2; k >= 0; k--) begin
            ready_s[k] = !valid_r[k] | ready_s[k+1];
        end
    end

    // Pipeline registers. Data loads only with a valid token, so X on idle
    // inputs never enters the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            if (ready_s[0]) begin
                valid_r[0] <= in_valid;
                if (in_valid) begin
                    stage_r[0] <= compute(a, b, sub);
                end
            end
            for (int k = 1; k < LAT; k++) begin
                if (ready_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    if (valid_r[k-1]) begin
                        stage_r[k] <= stage_r[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = valid_r[LAT-1];
    assign y         = stage_r[LAT-1][WIDTH:0];
    assign sat       = stage_r[LAT-1][WIDTH+1];

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe. It drives three instances: (WIDTH=4, LAT=2),
// (8, 1) and (8, 4). A queue-based model predicts out_valid, in_ready, y and sat
// on every cycle. Directed literal checks pin the model to known answers.
module tb_add_pipe;

    logic       clk;
    logic       rst_n;
    logic       iv  [3];
    logic       orr [3];
    logic       sb  [3];
    logic [7:0] aa  [3];
    logic [7:0] bb  [3];

    logic       ov0, ir0, st0;
    logic [4:0] y0;
    logic       ov1, ir1, st1;
    logic [8:0] y1;
    logic       ov2, ir2, st2;
    logic [8:0] y2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef ADD_PIPE_SAT_EN
    localparam int T1_Y = 15;  localparam int T1_S = 1;
    localparam int T2_Y = 0;   localparam int T2_S = 1;
    localparam int T6_Y = 255; localparam int T6_S = 1;
`else
    localparam int T1_Y = 17;  localparam int T1_S = 0;
    localparam int T2_Y = 30;  localparam int T2_S = 0;
    localparam int T6_Y = 510; localparam int T6_S = 0;
`endif

    add_pipe #(.WIDTH(4), .LAT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .a(aa[0][3:0]), .b(bb[0][3:0]), .sub(sb[0]),
        .out_valid(ov0), .out_ready(orr[0]), .y(y0), .sat(st0)
    );
    add_pipe #(.WIDTH(8), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .a(aa[1]), .b(bb[1]), .sub(sb[1]),
        .out_valid(ov1), .out_ready(orr[1]), .y(y1), .sat(st1)
    );
    add_pipe #(.WIDTH(8), .LAT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
        .a(aa[2]), .b(bb[2]), .sub(sb[2]),
        .out_valid(ov2), .out_ready(orr[2]), .y(y2), .sat(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    typedef struct {
        int y;
        bit st;
        int rdy;
    } item_t;

    item_t fifo [3][16];
    int    hd   [3] = '{0, 0, 0};
    int    tl   [3] = '{0, 0, 0};

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    function automatic int w_of(int i);
        return (i == 0) ? 4 : 8;
    endfunction

    // Reference arithmetic from plain integers.
    function automatic void calc(input int w, input int av, input int bv, input bit s,
                                 output int yv, output bit stv);
        stv = 1'b0;
        if (!s) begin
            yv = av + bv;
`ifdef ADD_PIPE_SAT_EN
            if (yv > (1 << w) - 1) begin
                yv  = (1 << w) - 1;
                stv = 1'b1;
            end
`endif
        end else begin
            yv = av - bv;
            if (yv < 0) begin
`ifdef ADD_PIPE_SAT_EN
                yv  = 0;
                stv = 1'b1;
`else
                yv = yv + (1 << (w + 1));
`endif
            end
        end
    endfunction

    function automatic bit exp_ov(int i);
        return (tl[i] - hd[i] > 0) && (fifo[i][hd[i] % 16].rdy <= cyc);
    endfunction

    function automatic bit exp_ir(int i);
        return (tl[i] - hd[i] < lat_of(i)) || (orr[i] == 1'b1);
    endfunction

    function automatic int act_ov(int i);
        case (i)
            0:       return int'(ov0);
            1:       return int'(ov1);
            default: return int'(ov2);
        endcase
    endfunction

    function automatic int act_ir(int i);
        case (i)
            0:       return int'(ir0);
            1:       return int'(ir1);
            default: return int'(ir2);
        endcase
    endfunction

    function automatic int act_y(int i);
        case (i)
            0:       return int'(y0);
            1:       return int'(y1);
            default: return int'(y2);
        endcase
    endfunction

    function automatic int act_st(int i);
        case (i)
            0:       return int'(st0);
            1:       return int'(st1);
            default: return int'(st2);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update at each rising edge: retire the head, then accept the input.
    always @(posedge clk) begin
        bit    ove;
        bit    ire;
        int    yv;
        bit    stv;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ove = exp_ov(i);
                ire = exp_ir(i);
                if (ove && orr[i]) hd[i]++;
                if (iv[i] && ire) begin
                    calc(w_of(i), int'(aa[i]) & ((1 << w_of(i)) - 1),
                         int'(bb[i]) & ((1 << w_of(i)) - 1), sb[i], yv, stv);
                    fifo[i][tl[i] % 16] = '{y: yv, st: stv, rdy: cyc + lat_of(i)};
                    tl[i]++;
                end
            end
        end
        cyc++;
    end

    // Asynchronous reset flushes the model.
    always @(negedge rst_n) begin
        for (int i = 0; i < 3; i++) hd[i] = tl[i];
    end

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk($sformatf("inst%0d rst out_valid", i), act_ov(i), 0);
                chk($sformatf("inst%0d rst y", i), act_y(i), 0);
            end else begin
                chk($sformatf("inst%0d out_valid", i), act_ov(i), exp_ov(i) ? 1 : 0);
                chk($sformatf("inst%0d in_ready", i), act_ir(i), exp_ir(i) ? 1 : 0);
                if (exp_ov(i)) begin
                    chk($sformatf("inst%0d y", i), act_y(i), fifo[i][hd[i] % 16].y);
                    chk($sformatf("inst%0d sat", i), act_st(i), int'(fifo[i][hd[i] % 16].st));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input bit v, input int a_v, input int b_v, input bit s_v);
        iv[i] = v;
        aa[i] = a_v[7:0];
        bb[i] = b_v[7:0];
        sb[i] = s_v;
    endtask

    task automatic drv8(input bit v, input int a_v, input int b_v, input bit s_v);
        drv(1, v, a_v, b_v, s_v);
        drv(2, v, a_v, b_v, s_v);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(i, 1'b0, 0, 0, 1'b0);
            orr[i] = 1'b1;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset in_ready", int'(ir0), 1);
        chk("reset out_valid", int'(ov0), 0);
        chk("reset y", int'(y0), 0);

        // 9 + 8 with a latency of two cycles.
        drv(0, 1'b1, 9, 8, 1'b0);
        tick();
        drv(0, 1'b0, 0, 0, 1'b0);
        chk("t1 not yet valid", int'(ov0), 0);
        tick();
        chk("t1 out_valid", int'(ov0), 1);
        chk("t1 y", int'(y0), T1_Y);
        chk("t1 sat", int'(st0), T1_S);
        tick();
        chk("t1 retired", int'(ov0), 0);

        // 3 - 5 borrows, then 5 - 3.
        drv(0, 1'b1, 3, 5, 1'b1);
        tick();
        drv(0, 1'b1, 5, 3, 1'b1);
        tick();
        chk("t2 borrow y", int'(y0), T2_Y);
        chk("t2 borrow sat", int'(st0), T2_S);
        drv(0, 1'b0, 0, 0, 1'b0);
        tick();
        chk("t2 diff y", int'(y0), 2);
        chk("t2 diff sat", int'(st0), 0);
        tick();

        // Sixteen back-to-back pairs that all sum to 15.
        for (int i = 0; i < 16; i++) begin
            drv(0, 1'b1, i, 15 - i, 1'b0);
            tick();
        end
        drv(0, 1'b0, 0, 0, 1'b0);
        repeat (4) tick();

        // Backpressure: fill both stages, hold a third input, then drain.
        orr[0] = 1'b0;
        drv(0, 1'b1, 1, 1, 1'b0);
        tick();
        drv(0, 1'b1, 2, 2, 1'b0);
        tick();
        drv(0, 1'b1, 3, 3, 1'b0);
        chk("t4 full in_ready", int'(ir0), 0);
        chk("t4 stalled y", int'(y0), 2);
        tick();
        chk("t4 held in_ready", int'(ir0), 0);
        chk("t4 held y", int'(y0), 2);
        orr[0] = 1'b1;
        #1;
        chk("t4 release in_ready", int'(ir0), 1);
        tick();
        drv(0, 1'b0, 0, 0, 1'b0);
        chk("t4 drain y1", int'(y0), 4);
        tick();
        chk("t4 drain y2", int'(y0), 6);
        repeat (3) tick();

        // Asynchronous reset with two results in flight.
        drv(0, 1'b1, 7, 1, 1'b0);
        tick();
        drv(0, 1'b1, 6, 1, 1'b0);
        tick();
        drv(0, 1'b0, 0, 0, 1'b0);
        chk("t5 in flight", int'(ov0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async out_valid", int'(ov0), 0);
        chk("t5 async y", int'(y0), 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t5 no stale", int'(ov0), 0);

        // Eight-bit instances with LAT=1 and LAT=4.
        drv8(1'b1, 255, 255, 1'b0);
        tick();
        drv8(1'b0, 0, 0, 1'b0);
        chk("t6 lat1 valid", int'(ov1), 1);
        chk("t6 lat1 y", int'(y1), T6_Y);
        chk("t6 lat1 sat", int'(st1), T6_S);
        chk("t6 lat4 early", int'(ov2), 0);
        tick();
        tick();
        chk("t6 lat4 still early", int'(ov2), 0);
        tick();
        chk("t6 lat4 valid", int'(ov2), 1);
        chk("t6 lat4 y", int'(y2), T6_Y);
        tick();
        for (int i = 0; i < 16; i++) begin
            drv8(1'b1, i, 15 - i, 1'b0);
            tick();
        end
        drv8(1'b1, 0, 1, 1'b1);
        tick();
        drv8(1'b0, 0, 0, 1'b0);
        repeat (8) tick();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("inst%0d drained", i), tl[i] - hd[i], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
